// File: rtl/icache_pkg.sv
// Shared constants and types for the direct-mapped instruction cache.
package icache_pkg;

    localparam int DEF_IDX_W  = 7;
    localparam int DEF_ADDR_W = 18;

    typedef logic [31:0] word_t;

    // Controller states.
    localparam logic [1:0] IC_IDLE  = 2'd0;
    localparam logic [1:0] IC_MISS  = 2'd1;
    localparam logic [1:0] IC_WAIT  = 2'd2;
    localparam logic [1:0] IC_DRAIN = 2'd3;

    // Registered fetch result presented to if_id.
    typedef struct packed {
        logic  valid;
        word_t inst;
        word_t pc;
    } fetch_out_t;

    // Word-aligned form of a byte address.
    function automatic word_t word_align(input word_t addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memctrl-side signals of the instruction cache.
interface icache_if;
    import icache_pkg::*;

    logic  if_req_i;
    word_t if_addr_i;
    logic  flush_i;
    logic  busy_o;
    logic  inst_valid_o;
    word_t inst_o;
    word_t pc_o;
    logic  mem_req_o;
    word_t mem_addr_o;
    logic  mem_grant_i;
    logic  mem_done_i;
    word_t mem_inst_i;

    // View from inside the cache.
    modport slave (
        input  if_req_i, if_addr_i, flush_i, mem_grant_i, mem_done_i, mem_inst_i,
        output busy_o, inst_valid_o, inst_o, pc_o, mem_req_o, mem_addr_o
    );

    // View from pc_reg / ex / memctrl driving the cache.
    modport master (
        output if_req_i, if_addr_i, flush_i, mem_grant_i, mem_done_i, mem_inst_i,
        input  busy_o, inst_valid_o, inst_o, pc_o, mem_req_o, mem_addr_o
    );

endinterface

// File: rtl/icache_ram.sv
// Line storage: valid flops cleared by reset, tag/data arrays that are never reset.
// One combinational lookup port, one synchronous fill port.
module icache_ram
    import icache_pkg::*;
#(
    parameter int IDX_W = DEF_IDX_W,
    parameter int TAG_W = DEF_ADDR_W - 2 - DEF_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output word_t            rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  word_t            wr_data
);

    localparam int LINES = 1 << IDX_W;

    logic [LINES-1:0] valid_reg;
    logic [TAG_W-1:0] tag_mem  [LINES];
    word_t            data_mem [LINES];

    genvar gi;
    generate
        for (gi = 0; gi < LINES; gi++) begin : g_valid
            // Each line's valid bit: cleared on reset, set when that line is filled.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (wr_en && (wr_idx == IDX_W'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    // Fill writes tag and data together.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_idx]  <= wr_tag;
            data_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_reg[rd_idx];
    assign rd_tag   = tag_mem[rd_idx];
    assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped one-word-per-line instruction cache between pc_reg and memctrl.
// Hits answer next cycle; misses fetch one word from memctrl, fill, then answer.
module icache
    import icache_pkg::*;
#(
    parameter int IDX_W  = DEF_IDX_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    icache_if.slave  bus
);

    localparam int TAG_W = ADDR_W - 2 - IDX_W;

    logic [1:0]       state_reg;
    word_t            miss_pc_reg;
    fetch_out_t       out_reg;
    logic             mem_req_reg;
    word_t            mem_addr_reg;

    logic [IDX_W-1:0] rd_idx;
    logic             rd_valid;
    logic [TAG_W-1:0] rd_tag;
    word_t            rd_data;
    logic             hit;
    logic             fill_en;

    assign rd_idx  = bus.if_addr_i[IDX_W+1:2];
    assign hit     = rd_valid && (rd_tag == bus.if_addr_i[ADDR_W-1:IDX_W+2]);
    // A returning word is always written, even when flushed: the data is still correct.
    assign fill_en = rdy && !rst && bus.mem_done_i
                     && ((state_reg == IC_WAIT) || (state_reg == IC_DRAIN));

    icache_ram #(
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_ram (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (rd_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill_en),
        .wr_idx   (miss_pc_reg[IDX_W+1:2]),
        .wr_tag   (miss_pc_reg[ADDR_W-1:IDX_W+2]),
        .wr_data  (bus.mem_inst_i)
    );

    // Miss FSM and output registers; everything holds while rdy is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IC_IDLE;
            miss_pc_reg  <= '0;
            out_reg      <= '0;
            mem_req_reg  <= 1'b0;
            mem_addr_reg <= '0;
        end else if (rdy) begin
            out_reg.valid <= 1'b0;
            case (state_reg)
                IC_IDLE: begin
                    if (!bus.flush_i && bus.if_req_i) begin
                        if (hit) begin
                            out_reg.valid <= 1'b1;
                            out_reg.inst  <= rd_data;
                            out_reg.pc    <= bus.if_addr_i;
                        end else begin
                            miss_pc_reg  <= bus.if_addr_i;
                            mem_req_reg  <= 1'b1;
                            mem_addr_reg <= word_align(bus.if_addr_i);
                            state_reg    <= IC_MISS;
                        end
                    end
                end
                IC_MISS: begin
                    if (bus.flush_i) begin
                        // A grant in the same cycle means memctrl is committed: drain it.
                        mem_req_reg <= 1'b0;
                        state_reg   <= bus.mem_grant_i ? IC_DRAIN : IC_IDLE;
                    end else if (bus.mem_grant_i) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= IC_WAIT;
                    end
                end
                IC_WAIT: begin
                    if (bus.mem_done_i) begin
                        state_reg <= IC_IDLE;
                        if (!bus.flush_i) begin
                            out_reg.valid <= 1'b1;
                            out_reg.inst  <= bus.mem_inst_i;
                            out_reg.pc    <= miss_pc_reg;
                        end
                    end else if (bus.flush_i) begin
                        state_reg <= IC_DRAIN;
                    end
                end
                default: begin
                    // Drain: swallow the word silently.
                    if (bus.mem_done_i) begin
                        state_reg <= IC_IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy_o       = (state_reg != IC_IDLE);
    assign bus.inst_valid_o = out_reg.valid;
    assign bus.inst_o       = out_reg.inst;
    assign bus.pc_o         = out_reg.pc;
    assign bus.mem_req_o    = mem_req_reg;
    assign bus.mem_addr_o   = mem_addr_reg;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: the bench plays pc_reg, ex and memctrl and
// predicts every output from a word-granular model of a direct-mapped cache.
module tb_icache;
    import icache_pkg::*;

    localparam int LINES = 1 << DEF_IDX_W;

    logic clk = 1'b0;
    logic rst;
    logic rdy;

    always #5 clk = ~clk;

    icache_if bus();

    icache #(
        .IDX_W  (DEF_IDX_W),
        .ADDR_W (DEF_ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: which memory word each line holds, and its contents.
    bit          m_valid [LINES];
    int unsigned m_word  [LINES];
    word_t       m_data  [LINES];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int unsigned word_no(input word_t a);
        int unsigned w;
        w = a;
        w = w % (32'd1 << DEF_ADDR_W);
        return w / 4;
    endfunction

    function automatic int unsigned line_of(input word_t a);
        return word_no(a) % LINES;
    endfunction

    function automatic bit m_hit(input word_t a);
        return m_valid[line_of(a)] && (m_word[line_of(a)] == word_no(a));
    endfunction

    task automatic m_fill(input word_t a, input word_t d);
        m_valid[line_of(a)] = 1'b1;
        m_word[line_of(a)]  = word_no(a);
        m_data[line_of(a)]  = d;
    endtask

    task automatic m_clear();
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic idle_inputs();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.flush_i     = 1'b0;
        bus.mem_grant_i = 1'b0;
        bus.mem_done_i  = 1'b0;
        bus.mem_inst_i  = '0;
        rdy             = 1'b1;
    endtask

    // One fetch. mode: 0 plain, 1 flush before grant, 2 flush in WAIT,
    // 3 flush with grant, 4 flush with done, 5 rdy low for 3 cycles in WAIT.
    task automatic fetch(input word_t a, input int mode, input word_t fill);
        bit hit;
        int dly;
        bit pulse;
        hit = m_hit(a);
        $display("[TB] fetch addr=%h mode=%0d %s", a, mode, hit ? "hit" : "miss");
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = a;
        @(negedge clk);
        bus.if_req_i  = 1'b0;
        bus.if_addr_i = $urandom;
        if (hit) begin
            check("hit_valid", bus.inst_valid_o, 1);
            check("hit_inst", bus.inst_o, m_data[line_of(a)]);
            check("hit_pc", bus.pc_o, a);
            check("hit_noreq", bus.mem_req_o, 0);
            check("hit_busy", bus.busy_o, 0);
            @(negedge clk);
            check("hit_pulse_end", bus.inst_valid_o, 0);
            return;
        end
        check("miss_req", bus.mem_req_o, 1);
        check("miss_addr", bus.mem_addr_o, {a[31:2], 2'b00});
        check("miss_busy", bus.busy_o, 1);
        check("miss_novalid", bus.inst_valid_o, 0);
        dly = $urandom_range(0, 2);
        repeat (dly) begin
            @(negedge clk);
            check("miss_hold", bus.mem_req_o, 1);
        end
        if (mode == 1) begin
            bus.flush_i = 1'b1;
            @(negedge clk);
            bus.flush_i = 1'b0;
            check("abort_req", bus.mem_req_o, 0);
            check("abort_busy", bus.busy_o, 0);
            check("abort_valid", bus.inst_valid_o, 0);
            return;
        end
        bus.mem_grant_i = 1'b1;
        bus.flush_i     = (mode == 3);
        @(negedge clk);
        bus.mem_grant_i = 1'b0;
        bus.flush_i     = 1'b0;
        check("grant_drop", bus.mem_req_o, 0);
        check("grant_busy", bus.busy_o, 1);
        if (mode == 2) begin
            bus.flush_i = 1'b1;
            @(negedge clk);
            bus.flush_i = 1'b0;
            check("drain_busy", bus.busy_o, 1);
            check("drain_valid", bus.inst_valid_o, 0);
        end
        dly = $urandom_range(0, 2);
        repeat (dly) begin
            @(negedge clk);
            check("wait_busy", bus.busy_o, 1);
            check("wait_valid", bus.inst_valid_o, 0);
        end
        if (mode == 5) begin
            rdy             = 1'b0;
            bus.mem_done_i  = 1'b1;
            bus.mem_inst_i  = ~fill;
            repeat (3) begin
                @(negedge clk);
                check("frz_busy", bus.busy_o, 1);
                check("frz_valid", bus.inst_valid_o, 0);
                check("frz_req", bus.mem_req_o, 0);
            end
            rdy = 1'b1;
        end
        bus.mem_done_i = 1'b1;
        bus.mem_inst_i = fill;
        bus.flush_i    = (mode == 4);
        @(negedge clk);
        bus.mem_done_i = 1'b0;
        bus.flush_i    = 1'b0;
        pulse = (mode == 0) || (mode == 5);
        check("done_valid", bus.inst_valid_o, pulse);
        if (pulse) begin
            check("done_inst", bus.inst_o, fill);
            check("done_pc", bus.pc_o, a);
        end
        check("done_busy", bus.busy_o, 0);
        m_fill(a, fill);
        @(negedge clk);
        check("pulse_end", bus.inst_valid_o, 0);
    endtask

    // Request with a same-cycle flush: must be dropped entirely.
    task automatic flush_req(input word_t a);
        $display("[TB] flush+req addr=%h", a);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = a;
        bus.flush_i   = 1'b1;
        @(negedge clk);
        bus.if_req_i  = 1'b0;
        bus.flush_i   = 1'b0;
        check("fr_valid", bus.inst_valid_o, 0);
        check("fr_req", bus.mem_req_o, 0);
        check("fr_busy", bus.busy_o, 0);
    endtask

    // Back-to-back requests to addresses the model says are cached.
    task automatic hit_burst(input word_t q[$]);
        $display("[TB] hit burst of %0d", q.size());
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = q[0];
        for (int k = 0; k < q.size(); k++) begin
            @(negedge clk);
            check("burst_valid", bus.inst_valid_o, 1);
            check("burst_inst", bus.inst_o, m_data[line_of(q[k])]);
            check("burst_pc", bus.pc_o, q[k]);
            check("burst_noreq", bus.mem_req_o, 0);
            if (k + 1 < q.size()) bus.if_addr_i = q[k+1];
            else bus.if_req_i = 1'b0;
        end
        @(negedge clk);
        check("burst_end", bus.inst_valid_o, 0);
    endtask

    function automatic word_t rand_addr();
        int unsigned tags [4];
        word_t a;
        tags = '{0, 1, 2, 256};
        a = (word_t'(tags[$urandom_range(0, 3)]) << (DEF_IDX_W + 2))
          | (word_t'($urandom_range(0, 15)) << 2)
          | word_t'($urandom_range(0, 3));
        if ($urandom_range(0, 1) == 1) a = a | ($urandom & 32'hFFFC_0000);
        return a;
    endfunction

    initial begin
        word_t q[$];
        word_t a;
        int r;

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy_o, 0);
        check("rst_valid", bus.inst_valid_o, 0);
        check("rst_inst", bus.inst_o, 0);
        check("rst_pc", bus.pc_o, 0);
        check("rst_req", bus.mem_req_o, 0);
        check("rst_maddr", bus.mem_addr_o, 0);
        rst = 1'b0;

        // Cold fetch, then refetch as a hit.
        fetch(32'h0, 0, 32'h0000_0013);
        fetch(32'h0, 0, 32'h0);
        fetch(32'h4, 0, 32'h1111_0004);
        fetch(32'h8, 0, 32'h2222_0008);
        fetch(32'hC, 0, 32'h3333_000C);
        q = '{32'h0, 32'h4, 32'h8, 32'hC};
        hit_burst(q);

        // Conflict on line 1: 0x204 evicts 0x4.
        fetch(32'h204, 0, 32'h4444_0204);
        fetch(32'h4, 0, 32'h5555_0004);

        // Flush in WAIT: silent fill, later hit.
        fetch(32'h100, 2, 32'hDEAD_BEEF);
        fetch(32'h100, 0, 32'h0);

        // Flush in MISS before grant: no fill, so it misses again.
        fetch(32'h300, 1, 32'h0);
        fetch(32'h300, 0, 32'h6666_0300);
        fetch(32'h400, 3, 32'h7777_0400);
        fetch(32'h500, 4, 32'h8888_0500);
        fetch(32'h600, 5, 32'h9999_0600);
        flush_req(32'h0);

        // Reset while waiting for memctrl.
        $display("[TB] reset during WAIT");
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h800;
        @(negedge clk);
        bus.if_req_i    = 1'b0;
        bus.mem_grant_i = 1'b1;
        @(negedge clk);
        bus.mem_grant_i = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_clear();
        check("rw_busy", bus.busy_o, 0);
        check("rw_req", bus.mem_req_o, 0);
        check("rw_valid", bus.inst_valid_o, 0);
        fetch(32'h0, 0, 32'hABCD_0000);

        // Randomized traffic.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            a = rand_addr();
            if (r < 6) begin
                fetch(a, (r < 4) ? 0 : $urandom_range(1, 5), $urandom);
            end else if (r == 6) begin
                flush_req(a);
            end else begin
                q = {};
                for (int l = 0; l < LINES; l++) begin
                    if (m_valid[l] && q.size() < 4 && $urandom_range(0, 1) == 1) begin
                        q.push_back((word_t'(m_word[l]) << 2) | word_t'($urandom_range(0, 3))
                                    | (($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFC_0000) : 32'h0));
                    end
                end
                if (q.size() > 0) hit_burst(q);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
